// File: rtl/udi_thr_event_mon_pkg.sv
// Shared constants for the UDI threshold event monitor: widths, cfg field layout, FSM encoding.
package udi_thr_event_mon_pkg;

  localparam int unsigned MON_CNT_W    = 8;
  localparam int unsigned MON_HOLD_W   = 16;
  localparam int unsigned MON_TOT_W    = 16;
  localparam int unsigned MON_DEF_TRIG = 4;

  localparam int unsigned CFG_W        = 32;
  localparam int unsigned CFG_TRIG_LSB = 0;
  localparam int unsigned CFG_HOLD_LSB = 8;
  localparam int unsigned CFG_EN_BIT   = 31;

  typedef enum logic [1:0] {
    MON_IDLE = 2'd0,
    MON_FIRE = 2'd1,
    MON_HOLD = 2'd2
  } mon_state_t;

endpackage

// File: rtl/udi_thr_event_mon_if.sv
// Compare-result, config and event handshake bundle between UDI datapath and the event monitor.
interface udi_thr_event_mon_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TOT_W = 16
);
  logic             mon_cmp_valid_m;
  logic             mon_cmp_hit_m;
  logic             mon_cfg_wr;
  logic [31:0]      mon_cfg_data;
  logic             mon_ev_ack;
  logic             mon_ev_req;
  logic [CNT_W-1:0] mon_run_cnt;
  logic [TOT_W-1:0] mon_ev_total;
  logic [1:0]       mon_state;

  modport master (
    output mon_cmp_valid_m, mon_cmp_hit_m, mon_cfg_wr, mon_cfg_data, mon_ev_ack,
    input  mon_ev_req, mon_run_cnt, mon_ev_total, mon_state
  );

  modport slave (
    input  mon_cmp_valid_m, mon_cmp_hit_m, mon_cfg_wr, mon_cfg_data, mon_ev_ack,
    output mon_ev_req, mon_run_cnt, mon_ev_total, mon_state
  );
endinterface

// File: rtl/udi_thr_event_mon_sat_cnt.sv
// Saturating up counter with synchronous clear (clear has priority over increment).
module udi_thr_event_mon_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/udi_thr_event_mon.sv
// Counts consecutive above-threshold compare results, raises a req/ack event at the
// programmed run length, then enforces a hold-off window before re-arming.
module udi_thr_event_mon
  import udi_thr_event_mon_pkg::*;
#(
  parameter int unsigned CNT_W    = MON_CNT_W,
  parameter int unsigned HOLD_W   = MON_HOLD_W,
  parameter int unsigned TOT_W    = MON_TOT_W,
  parameter int unsigned DEF_TRIG = MON_DEF_TRIG
) (
  input  logic                UDI_gclk,
  input  logic                UDI_greset,
  input  logic                UDI_gscanenable,
  udi_thr_event_mon_if.slave  mon
);

  mon_state_t        state;
  logic              ev_req;
  logic [HOLD_W-1:0] hold_cnt;
  logic              en_r;
  logic [CNT_W-1:0]  trig_r;
  logic [HOLD_W-1:0] hold_cfg_r;
  logic [HOLD_W-1:0] hold_act_r;
  logic [CNT_W-1:0]  run_cnt;
  logic [TOT_W-1:0]  ev_total;

  logic              active_c;
  logic              hit_c;
  logic [CNT_W-1:0]  run_inc_c;
  logic [CNT_W-1:0]  trig_eff_c;
  logic              fire_c;
  logic              run_clr_c;
  logic [HOLD_W-1:0] hold_nxt_c;

  // Scan enable only reaches the register cells; unused cfg bits are reserved.
  logic unused_ok;
  assign unused_ok = ^{UDI_gscanenable, mon.mon_cfg_data};

  // Trigger qualification; a same-cycle disable write overrides an imminent trigger.
  always_comb begin
    active_c   = en_r & ~(mon.mon_cfg_wr & ~mon.mon_cfg_data[CFG_EN_BIT]);
    hit_c      = mon.mon_cmp_valid_m & mon.mon_cmp_hit_m;
    run_inc_c  = (run_cnt == '1) ? run_cnt : run_cnt + CNT_W'(1);
    trig_eff_c = (trig_r == '0) ? CNT_W'(1) : trig_r;
    fire_c     = active_c && (state == MON_IDLE) && hit_c && (run_inc_c >= trig_eff_c);
    run_clr_c  = !active_c || (state != MON_IDLE) || fire_c ||
                 (mon.mon_cmp_valid_m && !mon.mon_cmp_hit_m);
    hold_nxt_c = mon.mon_cfg_wr ? mon.mon_cfg_data[CFG_HOLD_LSB +: HOLD_W] : hold_cfg_r;
  end

  // Config registers; hold-off is snapshotted while IDLE so FIRE/HOLD edits wait for re-entry.
  always_ff @(posedge UDI_gclk or posedge UDI_greset) begin
    if (UDI_greset) begin
      en_r       <= 1'b0;
      trig_r     <= CNT_W'(DEF_TRIG);
      hold_cfg_r <= '0;
      hold_act_r <= '0;
    end else begin
      if (mon.mon_cfg_wr) begin
        en_r       <= mon.mon_cfg_data[CFG_EN_BIT];
        trig_r     <= mon.mon_cfg_data[CFG_TRIG_LSB +: CNT_W];
        hold_cfg_r <= mon.mon_cfg_data[CFG_HOLD_LSB +: HOLD_W];
      end
      if (state == MON_IDLE) begin
        hold_act_r <= hold_nxt_c;
      end
    end
  end

  // Event FSM: IDLE arms, FIRE holds the request until ack, HOLD counts the hold-off window.
  always_ff @(posedge UDI_gclk or posedge UDI_greset) begin
    if (UDI_greset) begin
      state    <= MON_IDLE;
      ev_req   <= 1'b0;
      hold_cnt <= '0;
    end else if (!active_c) begin
      state    <= MON_IDLE;
      ev_req   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      case (state)
        MON_IDLE: begin
          if (fire_c) begin
            state  <= MON_FIRE;
            ev_req <= 1'b1;
          end
        end
        MON_FIRE: begin
          if (mon.mon_ev_ack) begin
            ev_req   <= 1'b0;
            hold_cnt <= hold_act_r;
            state    <= (hold_act_r == '0) ? MON_IDLE : MON_HOLD;
          end
        end
        MON_HOLD: begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
          if (hold_cnt <= HOLD_W'(1)) begin
            state <= MON_IDLE;
          end
        end
        default: begin
          state  <= MON_IDLE;
          ev_req <= 1'b0;
        end
      endcase
    end
  end

  // Consecutive-hit run length.
  udi_thr_event_mon_sat_cnt #(.W(CNT_W)) u_run_cnt (
    .clk (UDI_gclk),
    .rst (UDI_greset),
    .clr (run_clr_c),
    .inc (hit_c),
    .cnt (run_cnt)
  );

  // Events fired since reset.
  udi_thr_event_mon_sat_cnt #(.W(TOT_W)) u_ev_total (
    .clk (UDI_gclk),
    .rst (UDI_greset),
    .clr (1'b0),
    .inc (fire_c),
    .cnt (ev_total)
  );

  assign mon.mon_ev_req   = ev_req;
  assign mon.mon_run_cnt  = run_cnt;
  assign mon.mon_ev_total = ev_total;
  assign mon.mon_state    = state;

endmodule

// File: tb/tb_udi_thr_event_mon.sv
// Scoreboard bench for udi_thr_event_mon: directed scenarios plus random traffic vs a reference model.
module tb_udi_thr_event_mon;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned HOLD_W  = 16;
  localparam int unsigned TOT_W   = 4;
  localparam int          RUN_MAX = (1 << CNT_W) - 1;
  localparam int          TOT_MAX = (1 << TOT_W) - 1;

  typedef struct {
    int req;
    int run;
    int tot;
    int st;
  } exp_t;

  logic clk;
  logic rst;
  logic scan_en;

  udi_thr_event_mon_if #(.CNT_W(CNT_W), .TOT_W(TOT_W)) mif ();

  udi_thr_event_mon #(
    .CNT_W(CNT_W), .HOLD_W(HOLD_W), .TOT_W(TOT_W), .DEF_TRIG(4)
  ) dut (
    .UDI_gclk        (clk),
    .UDI_greset      (rst),
    .UDI_gscanenable (scan_en),
    .mon             (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state (state: 0 idle, 1 waiting for ack, 2 hold-off).
  int m_en, m_trig, m_hold, m_snap, m_state, m_req, m_run, m_tot, m_left;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] cfg(input int en, input int trig, input int hold);
    logic [31:0] d;
    d        = '0;
    d[31]    = (en != 0);
    d[23:8]  = 16'(hold);
    d[7:0]   = 8'(trig);
    return d;
  endfunction

  task automatic model_reset();
    m_en = 0; m_trig = 4; m_hold = 0; m_snap = 0;
    m_state = 0; m_req = 0; m_run = 0; m_tot = 0; m_left = 0;
  endtask

  // One clock of the specified behaviour, applied to the model.
  task automatic model_step(input logic v, input logic h, input logic wr,
                            input logic [31:0] d, input logic ack);
    int trig_eff;
    if (m_en == 0 || (wr && !d[31])) begin
      m_state = 0; m_req = 0; m_run = 0;
    end else if (m_state == 0) begin
      m_snap = wr ? int'(d[23:8]) : m_hold;
      if (v && h) begin
        m_run    = (m_run < RUN_MAX) ? m_run + 1 : RUN_MAX;
        trig_eff = (m_trig == 0) ? 1 : m_trig;
        if (m_run >= trig_eff) begin
          m_state = 1; m_req = 1; m_run = 0;
          if (m_tot < TOT_MAX) m_tot++;
        end
      end else if (v) begin
        m_run = 0;
      end
    end else if (m_state == 1) begin
      if (ack) begin
        m_req = 0;
        if (m_snap == 0) m_state = 0;
        else begin
          m_state = 2; m_left = m_snap;
        end
      end
    end else begin
      m_left--;
      if (m_left == 0) m_state = 0;
    end
    if (wr) begin
      m_en = int'(d[31]); m_trig = int'(d[7:0]); m_hold = int'(d[23:8]);
    end
  endtask

  // Drive one cycle of inputs and queue the expected post-edge outputs.
  task automatic step(input logic v, input logic h, input logic wr,
                      input logic [31:0] d, input logic ack);
    exp_t e;
    @(negedge clk);
    mif.mon_cmp_valid_m = v;
    mif.mon_cmp_hit_m   = h;
    mif.mon_cfg_wr      = wr;
    mif.mon_cfg_data    = d;
    mif.mon_ev_ack      = ack;
    model_step(v, h, wr, d, ack);
    e.req = m_req; e.run = m_run; e.tot = m_tot; e.st = m_state;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic hit(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic write_cfg(input int en, input int trig, input int hold);
    step(1'b0, 1'b0, 1'b1, cfg(en, trig, hold), 1'b0);
  endtask

  task automatic ack();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  // Monitor: after every active edge compare DUT outputs with the queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("ev_req",   int'(mif.mon_ev_req),   mon_e.req);
      check("run_cnt",  int'(mif.mon_run_cnt),  mon_e.run);
      check("ev_total", int'(mif.mon_ev_total), mon_e.tot);
      check("state",    int'(mif.mon_state),    mon_e.st);
    end
  end

  initial begin
    rst     = 1'b1;
    scan_en = 1'b0;
    mif.mon_cmp_valid_m = 1'b0;
    mif.mon_cmp_hit_m   = 1'b0;
    mif.mon_cfg_wr      = 1'b0;
    mif.mon_cfg_data    = '0;
    mif.mon_ev_ack      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ev_req",   int'(mif.mon_ev_req),   0);
    check("rst_run_cnt",  int'(mif.mon_run_cnt),  0);
    check("rst_ev_total", int'(mif.mon_ev_total), 0);
    check("rst_state",    int'(mif.mon_state),    0);
    rst = 1'b0;

    // Hits while disabled do nothing.
    hit(3);

    // Three consecutive hits fire with trig_n 3.
    write_cfg(1, 3, 0);
    hit(3);
    idle(2);
    hit(2);
    ack();
    idle(1);

    // Broken run never fires.
    step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Hold-off of 5 cycles; hits during hold are ignored; cfg edit in FIRE waits for IDLE.
    write_cfg(1, 3, 5);
    hit(3);
    write_cfg(1, 2, 9);
    ack();
    hit(7);
    idle(1);
    write_cfg(1, 3, 5);

    // trig_n 0 fires on a single hit; hold-off 0 returns straight to IDLE.
    write_cfg(1, 0, 0);
    hit(1);
    ack();
    hit(1);
    step(0, 0, 1, cfg(1, 0, 0), 1);
    idle(1);

    // Saturate the event total.
    write_cfg(1, 1, 0);
    for (int i = 0; i < TOT_MAX + 3; i++) begin
      hit(1);
      ack();
    end
    @(posedge clk); #2;
    check("ev_total_sat", int'(mif.mon_ev_total), TOT_MAX);

    // Disable in the same cycle as a trigger suppresses the event.
    step(1, 1, 1, cfg(0, 1, 0), 0);
    write_cfg(1, 2, 0);
    hit(1);
    step(1, 1, 1, cfg(0, 2, 0), 0);
    idle(1);

    // Async reset while FIRE is pending.
    write_cfg(1, 2, 3);
    hit(2);
    idle(1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_ev_req",   int'(mif.mon_ev_req),   0);
    check("arst_state",    int'(mif.mon_state),    0);
    check("arst_run_cnt",  int'(mif.mon_run_cnt),  0);
    check("arst_ev_total", int'(mif.mon_ev_total), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    write_cfg(1, 2, 2);
    for (int i = 0; i < 3000; i++) begin
      logic v, h, wr, a;
      logic [31:0] d;
      v  = ($urandom_range(99) < 75);
      h  = ($urandom_range(99) < 70);
      wr = ($urandom_range(99) < 4);
      a  = ($urandom_range(99) < 30);
      d  = cfg(($urandom_range(9) != 0) ? 1 : 0, int'($urandom_range(5)),
               int'($urandom_range(6)));
      d[30:24] = 7'($urandom);
      step(v, h, wr, d, a);
    end

    idle(2);
    @(posedge clk); #3;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
